div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Initiator/controller for the execute-stage multicycle unsigned divider (valid in, done out, res={rem,quot}).
//  Accepts RISC-V DIV/DIVU/REM/REMU and W variants, performs sign/width fixup and launches the divider.
//  Waits for completion, handles divide-by-zero and signed overflow without launching, returns one 64-bit result.
//  Holds the pipeline (busy) for the duration.
// PARAMETERS
//  XLEN      64  datapath width; only 64 supported (divider is 64/64 -> 128)
//  MAX_WAIT  32  watchdog: cycles in WAIT/DRAIN before err asserts
// PORTS
//  clk        in   1    clock
//  reset      in   1    synchronous, active-high reset
//  req_valid  in   1    operation request, sampled only in IDLE
//  req_op     in   3    div_op_t: DIV,DIVU,REM,REMU,DIVW,DIVUW,REMW,REMUW
//  src1       in   64   dividend
//  src2       in   64   divisor
//  flush      in   1    squash in-flight op (no resp produced)
//  busy       out  1    state!=IDLE; pipeline holds execute stage
//  resp_valid out  1    one-cycle pulse, result valid
//  resp_data  out  64   result
//  err        out  1    sticky watchdog error, cleared only by reset
//  div_valid  out  1    one-cycle launch pulse to divider
//  div_a      out  64   unsigned dividend, stable from launch until done
//  div_b      out  64   unsigned divisor, stable from launch until done
//  div_done   in   1    divider done; also high while the divider is idle
//  div_res    in   128  {remainder, quotient}
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, resp_valid=0, resp_data=0, div_valid=0, div_a=div_b=0, err=0, wait counter=0.
//  FSM states: IDLE, LAUNCH, WAIT, DONE, DRAIN.
//  IDLE: on req_valid, latch op and operands.
//   - divisor==0 or signed overflow -> DONE
//   - otherwise -> LAUNCH
//  LAUNCH: div_valid=1 for exactly this cycle -> WAIT. div_done is ignored in LAUNCH.
//   div_done is high in idle, so it must not be trusted before launch.
//  WAIT: on div_done -> DONE; latch fixed-up result.
//   Nominal divider latency is 16 cycles after launch.
//  DONE: resp_valid=1, resp_data=result for one cycle -> IDLE. busy stays 1 in DONE.
//  Req-to-resp latency:
//   - special cases: 2 cycles (IDLE accept, DONE)
//   - normal: 3+divider cycles (IDLE, LAUNCH, WAIT..., DONE)
//  Operand prep:
//   - W ops: sign-extend (signed) or zero-extend (unsigned) bits[31:0] of src1/src2.
//   - signed ops: div_a=|dividend|, div_b=|divisor| (two's complement abs; INT_MIN abs = INT_MIN as unsigned).
//  Result fixup:
//   - quotient negated iff signed and operand signs differ
//   - remainder takes the dividend's sign
//   - W ops: final result = sign-extend(bit 31) of 32-bit value, for signed and unsigned W ops alike
//  Divide-by-zero: quot=all ones (per width), rem=dividend (post width fixup). No launch.
//  Signed overflow (dividend=INT_MIN of width, divisor=-1): quot=INT_MIN (sign-extended for W), rem=0. No launch.
//  Flush:
//   - IDLE/DONE/LAUNCH-not-yet-sent: next state IDLE, no resp_valid. flush wins over DONE output.
//   - Flush in LAUNCH still emits div_valid that cycle, then goes to DRAIN.
//   - Flush in WAIT -> DRAIN, because the divider cannot be aborted.
//  DRAIN: busy=1, div_a/div_b held; on div_done -> IDLE, no resp. Later flushes are ignored.
//  Simultaneous flush and req_valid in IDLE: flush wins, request not accepted.
//  Watchdog: counter counts cycles in WAIT/DRAIN and clears on entry. Reaching MAX_WAIT sets err; FSM keeps waiting.
//  Reset mid-operation: returns to IDLE next cycle; divider shares reset, no drain needed.
// STRUCTURE
//  Package pipes: div_op_t enum; helpers is_signed(op), is_word(op), is_rem(op).
//  Package common: u64, u128.
//  Sub-module div_fixup (combinational): operand abs/extension plus special-case detect, and result sign/width fixup.
//  FSM, operand/result registers and watchdog stay in this module.
// TESTING
//  DIVU 100/7 -> div_valid pulse 1 cycle after accept; resp_data=14; busy falls after the resp cycle.
//  REM -7/2 -> resp_data=-1 (0xFFFF_FFFF_FFFF_FFFF); DIV -7/2 -> -3.
//  DIV x/0 -> resp_data=all ones at cycle 2, div_valid never asserted; REMU 5/0 -> 5.
//  DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000 and REM -> 0, no launch.
//  DIVW 0x1_8000_0000/0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 (overflow).
//  DIVUW 0xFFFF_FFFF/1 -> 0xFFFF_FFFF_FFFF_FFFF.
//  Flush 5 cycles into WAIT -> DRAIN, no resp_valid.
//   - next req_valid is ignored until div_done
//   - next op then returns the correct result
//  Reset asserted in WAIT -> all outputs 0 next cycle.
//  Divider model withholding done 40 cycles -> err=1 at WAIT+32, stays 1 until reset.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and opcode helpers for the
// execute-stage divider issue controller.
package div_issue_ctrl_pkg;

  typedef logic [63:0]  u64;
  typedef logic [127:0] u128;

  typedef enum logic [2:0] {
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU,
    OP_DIVW,
    OP_DIVUW,
    OP_REMW,
    OP_REMUW
  } div_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } div_state_t;

  function automatic logic is_signed(div_op_t op);
    return op inside {OP_DIV, OP_REM,
                      OP_DIVW, OP_REMW};
  endfunction

  function automatic logic is_word(div_op_t op);
    return op inside {OP_DIVW, OP_DIVUW,
                      OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_rem(div_op_t op);
    return op inside {OP_REM, OP_REMU,
                      OP_REMW, OP_REMUW};
  endfunction

  function automatic u64 sext32(logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // W results are always the sign-extended low word.
  function automatic u64 wfix(logic wd, u64 v);
    return wd ? sext32(v[31:0]) : v;
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Pipeline request/response and divider launch
// signals of the divider issue controller.
interface div_issue_ctrl_if;
  import div_issue_ctrl_pkg::*;

  logic    req_valid;
  div_op_t req_op;
  u64      src1;
  u64      src2;
  logic    flush;
  logic    busy;
  logic    resp_valid;
  u64      resp_data;
  logic    err;
  logic    div_valid;
  u64      div_a;
  u64      div_b;
  logic    div_done;
  u128     div_res;

  modport master (
    output req_valid, req_op, src1, src2,
    output flush, div_done, div_res,
    input  busy, resp_valid, resp_data, err,
    input  div_valid, div_a, div_b
  );

  modport slave (
    input  req_valid, req_op, src1, src2,
    input  flush, div_done, div_res,
    output busy, resp_valid, resp_data, err,
    output div_valid, div_a, div_b
  );

endinterface

// File: rtl/div_issue_ctrl_fixup.sv
// Operand sign/width prep, special-case detect
// and result fixup around the unsigned divider.
module div_fixup
  import div_issue_ctrl_pkg::*;
(
  input  div_op_t op,
  input  u64      src1,
  input  u64      src2,
  input  u128     res,
  output u64      div_a,
  output u64      div_b,
  output logic    special,
  output u64      special_res,
  output u64      fixed_res
);

  logic sgn, wd, rm;
  logic neg_a, neg_b;
  logic div0, ovf;
  u64   a_ext, b_ext, int_min;
  u64   sq, sr, q, r, fq, fr;

  assign sgn = is_signed(op);
  assign wd  = is_word(op);
  assign rm  = is_rem(op);

  assign a_ext = !wd ? src1 :
                 sgn ? sext32(src1[31:0]) :
                 {32'b0, src1[31:0]};
  assign b_ext = !wd ? src2 :
                 sgn ? sext32(src2[31:0]) :
                 {32'b0, src2[31:0]};

  assign neg_a = sgn & a_ext[63];
  assign neg_b = sgn & b_ext[63];

  assign div_a = neg_a ? -a_ext : a_ext;
  assign div_b = neg_b ? -b_ext : b_ext;

  assign int_min = wd ? sext32(32'h8000_0000)
                      : {1'b1, 63'b0};

  assign div0 = (b_ext == '0);
  assign ovf  = sgn & (b_ext == '1) &
                (a_ext == int_min);
  assign special = div0 | ovf;

  assign sq = div0 ? '1 : a_ext;
  assign sr = div0 ? a_ext : '0;
  assign special_res = wfix(wd, rm ? sr : sq);

  assign q  = res[63:0];
  assign r  = res[127:64];
  assign fq = (neg_a ^ neg_b) ? -q : q;
  assign fr = neg_a ? -r : r;
  assign fixed_res = wfix(wd, rm ? fr : fq);

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue controller: accepts M-extension divides,
// launches the divider, returns one result.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int MAX_WAIT = 32
) (
  input logic       clk,
  input logic       reset,
  div_issue_ctrl_if.slave bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  div_state_t      state;
  div_op_t         op_q;
  logic [XLEN-1:0] src1_q;
  logic [XLEN-1:0] src2_q;
  logic [XLEN-1:0] res_q;
  u64              div_a_q;
  u64              div_b_q;
  logic [CW-1:0]   cnt;
  logic            err_q;

  logic    idle;
  logic    waiting;
  div_op_t f_op;
  u64      f_src1, f_src2;
  u64      f_a, f_b;
  logic    f_special;
  u64      f_special_res;
  u64      f_fixed_res;

  assign idle    = (state == S_IDLE);
  assign waiting = (state == S_WAIT) ||
                   (state == S_DRAIN);

  // In IDLE the live request is classified;
  // afterwards the latched operands are used.
  assign f_op   = idle ? bus.req_op : op_q;
  assign f_src1 = idle ? bus.src1 : src1_q;
  assign f_src2 = idle ? bus.src2 : src2_q;

  div_fixup u_fixup (
    .op          (f_op),
    .src1        (f_src1),
    .src2        (f_src2),
    .res         (bus.div_res),
    .div_a       (f_a),
    .div_b       (f_b),
    .special     (f_special),
    .special_res (f_special_res),
    .fixed_res   (f_fixed_res)
  );

  // Main sequencer: accept, launch, wait, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= OP_DIV;
      src1_q  <= '0;
      src2_q  <= '0;
      res_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            op_q   <= bus.req_op;
            src1_q <= bus.src1;
            src2_q <= bus.src2;
            if (f_special) begin
              res_q <= f_special_res;
              state <= S_DONE;
            end else begin
              div_a_q <= f_a;
              div_b_q <= f_b;
              state   <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          state <= bus.flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (bus.flush) begin
            state <= S_DRAIN;
          end else if (bus.div_done) begin
            res_q <= f_fixed_res;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_DRAIN: begin
          if (bus.div_done) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Watchdog on time spent waiting for the divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state == S_LAUNCH) ||
          (state == S_WAIT && bus.flush)) begin
        cnt <= '0;
      end else if (waiting &&
                   cnt != CW'(MAX_WAIT)) begin
        cnt <= cnt + 1'b1;
      end
      if (waiting && cnt == CW'(MAX_WAIT - 1)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.busy       = !idle;
  assign bus.div_valid  = (state == S_LAUNCH);
  assign bus.resp_valid = (state == S_DONE) &&
                          !bus.flush;
  assign bus.resp_data  = res_q;
  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomised bench for div_issue_ctrl with a
// latency-configurable divider model.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  div_issue_ctrl_if bus();

  div_issue_ctrl #(
    .XLEN     (64),
    .MAX_WAIT (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_resp = 0;

  int unsigned lat_cfg = 16;
  int unsigned dcnt = 0;
  u128 dres = '0;

  // Divider model: done drops for lat_cfg cycles.
  always @(posedge clk) begin
    if (reset) begin
      dcnt <= 0;
    end else if (bus.div_valid) begin
      dcnt <= lat_cfg;
      if (bus.div_b != 0)
        dres <= {bus.div_a % bus.div_b,
                 bus.div_a / bus.div_b};
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end

  assign bus.div_done = (dcnt == 0);
  assign bus.div_res  = dres;

  always @(negedge clk)
    if (bus.resp_valid) n_resp <= n_resp + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  function automatic bit m_sgn(div_op_t op);
    return op == OP_DIV || op == OP_REM ||
           op == OP_DIVW || op == OP_REMW;
  endfunction

  function automatic bit m_w(div_op_t op);
    return op == OP_DIVW || op == OP_DIVUW ||
           op == OP_REMW || op == OP_REMUW;
  endfunction

  function automatic bit m_rem(div_op_t op);
    return op == OP_REM || op == OP_REMU ||
           op == OP_REMW || op == OP_REMUW;
  endfunction

  function automatic bit m_special(div_op_t op,
                                   u64 a, u64 b);
    if (m_w(op))
      return b[31:0] == 0 ||
             (m_sgn(op) &&
              a[31:0] == 32'h8000_0000 &&
              b[31:0] == 32'hFFFF_FFFF);
    return b == 0 ||
           (m_sgn(op) && a == 64'h8000_0000_0000_0000 &&
            b == '1);
  endfunction

  function automatic u64 model(div_op_t op,
                               u64 a, u64 b);
    logic [31:0] a32, b32, q32, r32, v32;
    u64 q, r;
    if (m_w(op)) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) begin
        q32 = '1; r32 = a32;
      end else if (m_sgn(op) &&
                   a32 == 32'h8000_0000 &&
                   b32 == '1) begin
        q32 = a32; r32 = 0;
      end else if (m_sgn(op)) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      v32 = m_rem(op) ? r32 : q32;
      return {{32{v32[31]}}, v32};
    end
    if (b == 0) begin
      q = '1; r = a;
    end else if (m_sgn(op) &&
                 a == 64'h8000_0000_0000_0000 &&
                 b == '1) begin
      q = a; r = 0;
    end else if (m_sgn(op)) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return m_rem(op) ? r : q;
  endfunction

  // Called at a negedge with the DUT idle.
  task automatic run_op(input div_op_t op,
                        input u64 a, input u64 b,
                        input int unsigned lat,
                        input u64 exp,
                        input string tag);
    int n, launches, first;
    bit seen, sp;
    u64 got;
    sp = m_special(op, a, b);
    lat_cfg = lat;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.src1 = a;
    bus.src2 = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
    seen = 0; launches = 0; first = 0;
    got = '0;
    for (n = 1; n <= 100; n++) begin
      if (bus.div_valid) begin
        launches++;
        if (launches == 1) first = n;
      end
      if (bus.resp_valid) begin
        seen = 1;
        got = bus.resp_data;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " resp"}, 64'(seen), 64'd1);
    chk({tag, " data"}, got, exp);
    if (sp) begin
      chk({tag, " launches"}, 64'(launches), 0);
      chk({tag, " latency"}, 64'(n), 64'd1);
    end else begin
      chk({tag, " launches"}, 64'(launches), 1);
      chk({tag, " launch at"}, 64'(first), 1);
    end
    @(negedge clk);
    chk({tag, " busy after"}, 64'(bus.busy), 0);
    chk({tag, " pulse"}, 64'(bus.resp_valid), 0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 100 && bus.busy; k++)
      @(negedge clk);
    chk({tag, " reached idle"},
        64'(bus.busy), 0);
  endtask

  typedef struct {
    div_op_t op;
    u64 a;
    u64 b;
    u64 exp;
  } vec_t;

  vec_t dir [14];

  function automatic u64 pick();
    unique case ($urandom_range(0, 5))
      0: return {$urandom, $urandom};
      1: return '0;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return {$urandom, 32'h8000_0000};
      default:
        return u64'($urandom_range(0, 20)) -
               u64'(10);
    endcase
  endfunction

  initial begin
    int r0, k;
    div_op_t op;
    u64 a, b;
    bus.req_valid = 1'b0;
    bus.req_op = OP_DIV;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.flush = 1'b0;

    dir[0]  = '{OP_DIVU, 100, 7, 14};
    dir[1]  = '{OP_REM, -64'sd7, 2, '1};
    dir[2]  = '{OP_DIV, -64'sd7, 2,
                64'hFFFF_FFFF_FFFF_FFFD};
    dir[3]  = '{OP_DIV, 123, 0, '1};
    dir[4]  = '{OP_REMU, 5, 0, 5};
    dir[5]  = '{OP_DIV, 64'h8000_0000_0000_0000,
                '1, 64'h8000_0000_0000_0000};
    dir[6]  = '{OP_REM, 64'h8000_0000_0000_0000,
                '1, 0};
    dir[7]  = '{OP_DIVW, 64'h1_8000_0000,
                64'hFFFF_FFFF,
                64'hFFFF_FFFF_8000_0000};
    dir[8]  = '{OP_DIVUW, 64'hFFFF_FFFF, 1, '1};
    dir[9]  = '{OP_REMW, 64'h1_FFFF_FFF9, 2, '1};
    dir[10] = '{OP_DIV, 7, -64'sd2,
                64'hFFFF_FFFF_FFFF_FFFD};
    dir[11] = '{OP_REMUW, 64'h1_0000_0007, 0, 7};
    dir[12] = '{OP_DIVW, 0, 0, '1};
    dir[13] = '{OP_DIVUW, 64'h8000_0000, 16,
                64'h0800_0000};

    repeat (2) @(negedge clk);
    chk("rst busy", 64'(bus.busy), 0);
    chk("rst resp_valid", 64'(bus.resp_valid), 0);
    chk("rst resp_data", bus.resp_data, 0);
    chk("rst div_valid", 64'(bus.div_valid), 0);
    chk("rst div_a", bus.div_a, 0);
    chk("rst div_b", bus.div_b, 0);
    chk("rst err", 64'(bus.err), 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (dir[i])
      run_op(dir[i].op, dir[i].a, dir[i].b, 16,
             dir[i].exp, $sformatf("dir%0d", i));

    for (int i = 0; i < 40; i++) begin
      op = div_op_t'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(op, a, b, $urandom_range(1, 20),
             model(op, a, b),
             $sformatf("rnd%0d op%0d", i, op));
    end

    // Flush and request together in IDLE.
    r0 = n_resp;
    bus.req_valid = 1'b1;
    bus.req_op = OP_DIV;
    bus.src1 = 9;
    bus.src2 = 0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    chk("idle flush busy", 64'(bus.busy), 0);
    repeat (2) @(negedge clk);
    chk("idle flush resp", 64'(n_resp), 64'(r0));

    // Flush while in DONE suppresses the response.
    bus.req_valid = 1'b1;
    bus.req_op = OP_REMU;
    bus.src1 = 5;
    bus.src2 = 0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush = 1'b1;
    #1;
    chk("done flush resp", 64'(bus.resp_valid), 0);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("done flush busy", 64'(bus.busy), 0);

    // Flush in LAUNCH: pulse still sent, drains.
    r0 = n_resp;
    lat_cfg = 10;
    bus.req_valid = 1'b1;
    bus.req_op = OP_DIVU;
    bus.src1 = 77;
    bus.src2 = 7;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush = 1'b1;
    #1;
    chk("launch flush dv", 64'(bus.div_valid), 1);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("launch flush drain", 64'(bus.busy), 1);
    wait_idle("launch flush");
    @(negedge clk);
    chk("launch flush resp", 64'(n_resp), 64'(r0));

    // Flush 5 cycles into WAIT, requests ignored.
    r0 = n_resp;
    lat_cfg = 16;
    bus.req_valid = 1'b1;
    bus.req_op = OP_DIVU;
    bus.src1 = 1000;
    bus.src2 = 3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op = OP_DIVU;
    bus.src1 = 50;
    bus.src2 = 5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("drain busy%0d", i),
          64'(bus.busy), 1);
      chk($sformatf("drain no dv%0d", i),
          64'(bus.div_valid), 0);
    end
    bus.req_valid = 1'b0;
    wait_idle("drain");
    @(negedge clk);
    chk("drain resp", 64'(n_resp), 64'(r0));
    run_op(OP_DIVU, 50, 5, 16, 10, "post drain");

    // Reset in WAIT clears every output.
    bus.req_valid = 1'b1;
    bus.req_op = OP_DIV;
    bus.src1 = -64'sd99;
    bus.src2 = 4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid rst busy", 64'(bus.busy), 0);
    chk("mid rst resp_valid",
        64'(bus.resp_valid), 0);
    chk("mid rst resp_data", bus.resp_data, 0);
    chk("mid rst div_valid",
        64'(bus.div_valid), 0);
    chk("mid rst div_a", bus.div_a, 0);
    chk("mid rst div_b", bus.div_b, 0);
    @(negedge clk);

    // Watchdog: divider withholds done 40 cycles.
    lat_cfg = 40;
    bus.req_valid = 1'b1;
    bus.req_op = OP_DIV;
    bus.src1 = 1000;
    bus.src2 = 7;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (k = 1; k < 100 && !bus.resp_valid; k++) begin
      if (k == 33)
        chk("wd err early", 64'(bus.err), 0);
      if (k == 34)
        chk("wd err set", 64'(bus.err), 1);
      @(negedge clk);
    end
    chk("wd resp", 64'(bus.resp_valid), 1);
    chk("wd data", bus.resp_data, 142);
    @(negedge clk);
    run_op(OP_REMU, 100, 7, 5, 2, "wd after");
    chk("wd sticky", 64'(bus.err), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("wd cleared", 64'(bus.err), 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
